// File: rtl/instr_reg_scheduler.sv
// Sequencing controller for a 32-entry instruction register used as an in-order queue.
// Two round-robin write requesters, one read requester, occupancy tracking and reset hold.
module instr_reg_scheduler #(
  parameter int DEPTH      = 32,
  parameter int RST_CYCLES = 2,
  parameter int OPCODE_W   = 4,
  parameter int OPERAND_W  = 16,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic [1:0]                          wr_req,
  input  logic [1:0][OPCODE_W-1:0]            wr_opcode,
  input  logic [1:0][OPERAND_W-1:0]           wr_op_a,
  input  logic [1:0][OPERAND_W-1:0]           wr_op_b,
  output logic [1:0]                          wr_gnt,
  input  logic                                rd_req,
  output logic                                rd_gnt,
  output logic                                rd_valid,
  output logic [AW-1:0]                       rd_addr,
  output logic                                reg_reset_n,
  output logic                                load_en,
  output logic [OPCODE_W-1:0]                 opcode,
  output logic [OPERAND_W-1:0]                operand_a,
  output logic [OPERAND_W-1:0]                operand_b,
  output logic [AW-1:0]                       write_pointer,
  output logic [AW-1:0]                       read_pointer,
  output logic [CW-1:0]                       count,
  output logic                                full,
  output logic                                empty
);

  localparam int HCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [0:0] HOLD = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]     state_reg;
  logic [HCW-1:0] hold_cnt_reg;
  logic           last_gnt_reg;   // index of the requester granted most recently
  logic [AW-1:0]  wr_idx_reg;
  logic [AW-1:0]  rd_idx_reg;

  logic           wr_any;
  logic           wr_sel;
  logic [CW-1:0]  count_next;

  // Full blocks writes only, so a full queue with both requests pops and refuses the push.
  always_comb begin
    wr_gnt = 2'b00;
    rd_gnt = 1'b0;
    if (state_reg == RUN && !reset && !flush) begin
      rd_gnt = rd_req && !empty;
      if (!full) begin
        if (wr_req == 2'b11)
          wr_gnt = last_gnt_reg ? 2'b01 : 2'b10;
        else
          wr_gnt = wr_req;
      end
    end
  end

  assign wr_any     = |wr_gnt;
  assign wr_sel     = wr_gnt[1];
  assign count_next = count + CW'(wr_any) - CW'(rd_gnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= HOLD;
      hold_cnt_reg  <= '0;
      last_gnt_reg  <= 1'b1;
      wr_idx_reg    <= '0;
      rd_idx_reg    <= '0;
      reg_reset_n   <= 1'b0;
      load_en       <= 1'b0;
      opcode        <= '0;
      operand_a     <= '0;
      operand_b     <= '0;
      write_pointer <= '0;
      read_pointer  <= '0;
      rd_addr       <= '0;
      rd_valid      <= 1'b0;
      count         <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
    end else begin
      load_en  <= wr_any;
      rd_valid <= rd_gnt;
      count    <= count_next;
      full     <= (count_next == CW'(DEPTH));
      empty    <= (count_next == '0);

      if (wr_any) begin
        opcode        <= wr_opcode[wr_sel];
        operand_a     <= wr_op_a[wr_sel];
        operand_b     <= wr_op_b[wr_sel];
        write_pointer <= wr_idx_reg;
        wr_idx_reg    <= wr_idx_reg + AW'(1);
        last_gnt_reg  <= wr_sel;
      end

      if (rd_gnt) begin
        read_pointer <= rd_idx_reg;
        rd_addr      <= rd_idx_reg;
        rd_idx_reg   <= rd_idx_reg + AW'(1);
      end

      case (state_reg)
        HOLD: begin
          if (flush) begin
            hold_cnt_reg <= '0;
          end else if (hold_cnt_reg == HCW'(RST_CYCLES - 1)) begin
            state_reg    <= RUN;
            reg_reset_n  <= 1'b1;
            hold_cnt_reg <= '0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HCW'(1);
          end
        end
        default: begin
          // Flush discards the queue; the register is re-reset before reuse.
          if (flush) begin
            state_reg     <= HOLD;
            hold_cnt_reg  <= '0;
            reg_reset_n   <= 1'b0;
            load_en       <= 1'b0;
            wr_idx_reg    <= '0;
            rd_idx_reg    <= '0;
            write_pointer <= '0;
            read_pointer  <= '0;
            rd_addr       <= '0;
            rd_valid      <= 1'b0;
            count         <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_reg_scheduler.sv
// Self-checking bench for instr_reg_scheduler: directed table, hand sequences for
// wrap/full/empty/flush corners, and randomized traffic against a queue-based model.
module tb_instr_reg_scheduler;

  localparam int DEPTH = 32;
  localparam int RST_CYCLES = 2;
  localparam int AW = 5;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic reset, flush, rd_req;
  logic [1:0] wr_req;
  logic [1:0][3:0] wr_opcode;
  logic [1:0][15:0] wr_op_a, wr_op_b;
  logic [1:0] wr_gnt;
  logic rd_gnt, rd_valid, reg_reset_n, load_en, full, empty;
  logic [AW-1:0] rd_addr, write_pointer, read_pointer;
  logic [3:0] opcode;
  logic [15:0] operand_a, operand_b;
  logic [CW-1:0] count;

  instr_reg_scheduler #(.DEPTH(DEPTH), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_req(wr_req), .wr_opcode(wr_opcode), .wr_op_a(wr_op_a), .wr_op_b(wr_op_b),
    .wr_gnt(wr_gnt), .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
    .rd_addr(rd_addr), .reg_reset_n(reg_reset_n), .load_en(load_en),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .write_pointer(write_pointer), .read_pointer(read_pointer),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Stand-in for the instruction register: captures whatever load_en writes.
  logic [35:0] tb_mem [DEPTH];
  always @(posedge clk) if (load_en) tb_mem[write_pointer] <= {opcode, operand_a, operand_b};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: queue contents plus plain integer indices.
  logic [35:0] q[$];
  bit  m_run;
  int  m_hold, m_last, m_wr_idx, m_rd_idx;
  logic e_rrn, e_load, e_rvalid;
  logic [3:0] e_op;
  logic [15:0] e_a, e_b;
  int e_wp, e_rp, e_raddr;
  logic [35:0] e_pop;
  logic [1:0] s_wgnt;
  logic s_rgnt;

  task automatic model_reset();
    m_run = 0; m_hold = 0; m_last = 1; m_wr_idx = 0; m_rd_idx = 0;
    q.delete();
    e_rrn = 0; e_load = 0; e_rvalid = 0; e_op = 0; e_a = 0; e_b = 0;
    e_wp = 0; e_rp = 0; e_raddr = 0; e_pop = '0;
  endtask

  task automatic model_grants(output logic [1:0] gw, output logic gr);
    gw = 2'b00; gr = 1'b0;
    if (m_run && !reset && !flush) begin
      gr = rd_req && (q.size() > 0);
      if (q.size() < DEPTH) begin
        if (wr_req[0] && (!wr_req[1] || m_last == 1)) gw = 2'b01;
        else if (wr_req[1]) gw = 2'b10;
      end
    end
  endtask

  task automatic model_step(input logic [1:0] gw, input logic gr);
    int k;
    if (reset) begin
      model_reset();
      return;
    end
    e_load = (gw != 0);
    e_rvalid = gr;
    if (gr) begin
      e_pop = q.pop_front();
      e_rp = m_rd_idx; e_raddr = m_rd_idx;
      m_rd_idx = (m_rd_idx + 1) % DEPTH;
    end
    if (gw != 0) begin
      k = gw[1] ? 1 : 0;
      q.push_back({wr_opcode[k], wr_op_a[k], wr_op_b[k]});
      e_op = wr_opcode[k]; e_a = wr_op_a[k]; e_b = wr_op_b[k];
      e_wp = m_wr_idx;
      m_wr_idx = (m_wr_idx + 1) % DEPTH;
      m_last = k;
    end
    if (!m_run) begin
      if (flush) m_hold = 0;
      else begin
        m_hold++;
        if (m_hold == RST_CYCLES) begin m_run = 1; m_hold = 0; e_rrn = 1; end
      end
    end else if (flush) begin
      m_run = 0; m_hold = 0; e_rrn = 0; e_load = 0; e_rvalid = 0;
      q.delete(); m_wr_idx = 0; m_rd_idx = 0;
      e_wp = 0; e_rp = 0; e_raddr = 0;
    end
  endtask

  // One clock: inputs already set at the falling edge; ends at the next falling edge.
  task automatic cycle();
    logic [1:0] gw;
    logic gr;
    #1;
    model_grants(gw, gr);
    s_wgnt = wr_gnt; s_rgnt = rd_gnt;
    chk("wr_gnt", wr_gnt, gw);
    chk("rd_gnt", rd_gnt, gr);
    @(posedge clk);
    model_step(gw, gr);
    #1;
    chk("reg_reset_n", reg_reset_n, e_rrn);
    chk("load_en", load_en, e_load);
    chk("opcode", opcode, e_op);
    chk("operand_a", operand_a, e_a);
    chk("operand_b", operand_b, e_b);
    chk("write_pointer", write_pointer, e_wp);
    chk("read_pointer", read_pointer, e_rp);
    chk("rd_addr", rd_addr, e_raddr);
    chk("rd_valid", rd_valid, e_rvalid);
    chk("count", count, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("empty", empty, q.size() == 0);
    if (e_rvalid) chk("rd_data", tb_mem[rd_addr], e_pop);
    @(negedge clk);
  endtask

  task automatic set_ops();
    wr_opcode[0] = 4'd1; wr_op_a[0] = 16'd5; wr_op_b[0] = 16'd3;
    wr_opcode[1] = 4'd2; wr_op_a[1] = 16'd7; wr_op_b[1] = 16'd9;
  endtask

  typedef struct {
    logic [1:0] wr;
    logic rd, fl;
    logic [1:0] x_wgnt;
    logic x_rgnt;
    int x_count;
    logic x_load;
    int x_wp;
  } vec_t;
  vec_t tbl[8];

  int saved_wp;

  initial begin
    tbl[0] = '{2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 1, 1'b1, 0};
    tbl[1] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 0, 1'b0, 0};
    tbl[2] = '{2'b11, 1'b0, 1'b0, 2'b10, 1'b0, 1, 1'b1, 1};
    tbl[3] = '{2'b11, 1'b0, 1'b0, 2'b01, 1'b0, 2, 1'b1, 2};
    tbl[4] = '{2'b11, 1'b0, 1'b0, 2'b10, 1'b0, 3, 1'b1, 3};
    tbl[5] = '{2'b11, 1'b0, 1'b0, 2'b01, 1'b0, 4, 1'b1, 4};
    tbl[6] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 3, 1'b0, 4};
    tbl[7] = '{2'b11, 1'b1, 1'b1, 2'b00, 1'b0, 0, 1'b0, 0};

    reset = 1; flush = 0; rd_req = 0; wr_req = 2'b11;
    set_ops();
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle();
    chk("reset_empty", empty, 1'b1);
    chk("reset_count", count, 0);

    // Hold after reset release: exactly two cycles low, no grants despite requests.
    reset = 0;
    cycle();
    chk("hold1_gnt", s_wgnt, 2'b00);
    chk("hold1_rrn", reg_reset_n, 1'b0);
    cycle();
    chk("hold2_gnt", s_wgnt, 2'b00);
    chk("hold2_rrn", reg_reset_n, 1'b1);
    wr_req = 2'b00;

    foreach (tbl[i]) begin
      wr_req = tbl[i].wr; rd_req = tbl[i].rd; flush = tbl[i].fl;
      cycle();
      chk($sformatf("tbl%0d_wgnt", i), s_wgnt, tbl[i].x_wgnt);
      chk($sformatf("tbl%0d_rgnt", i), s_rgnt, tbl[i].x_rgnt);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].x_count);
      chk($sformatf("tbl%0d_load", i), load_en, tbl[i].x_load);
      chk($sformatf("tbl%0d_wp", i), write_pointer, tbl[i].x_wp);
    end
    flush = 0; rd_req = 0;

    // Post-flush hold, then fill to full starting at location 0.
    wr_req = 2'b01;
    cycle();
    chk("fl_hold1_rrn", reg_reset_n, 1'b0);
    cycle();
    chk("fl_hold2_rrn", reg_reset_n, 1'b1);
    chk("fl_hold_gnt", s_wgnt, 2'b00);
    cycle();
    chk("fl_first_wp", write_pointer, 0);
    for (int i = 1; i < DEPTH; i++) begin
      wr_op_a[0] = 16'(i);
      cycle();
    end
    chk("fill_full", full, 1'b1);
    chk("fill_count", count, DEPTH);
    wr_req = 2'b11; rd_req = 1;
    cycle();
    chk("full_wgnt", s_wgnt, 2'b00);
    chk("full_rgnt", s_rgnt, 1'b1);
    chk("full_rvalid", rd_valid, 1'b1);
    chk("full_raddr", rd_addr, 0);
    chk("full_count", count, DEPTH - 1);
    wr_req = 2'b01; rd_req = 0;
    cycle();
    chk("wrap_wp", write_pointer, 0);

    // Drain, then read and write together on an empty queue.
    wr_req = 2'b00; rd_req = 1;
    for (int i = 0; i < 2 * DEPTH && count != 0; i++) cycle();
    chk("drained", empty, 1'b1);
    wr_req = 2'b01; wr_op_a[0] = 16'hBEEF;
    cycle();
    chk("empty_rgnt", s_rgnt, 1'b0);
    saved_wp = write_pointer;
    chk("empty_wp", saved_wp, 1);
    wr_req = 2'b00;
    cycle();
    chk("after_rgnt", s_rgnt, 1'b1);
    chk("after_rvalid", rd_valid, 1'b1);
    chk("after_raddr", rd_addr, saved_wp);
    rd_req = 0;

    // Randomized traffic with phases that push toward full and toward empty.
    for (int i = 0; i < 4000; i++) begin
      bit wheavy;
      wheavy = ((i / 150) % 2) == 0;
      reset = ($urandom_range(0, 499) == 0);
      flush = ($urandom_range(0, 79) == 0);
      wr_req[0] = $urandom_range(0, 99) < (wheavy ? 70 : 25);
      wr_req[1] = $urandom_range(0, 99) < (wheavy ? 70 : 25);
      rd_req = $urandom_range(0, 99) < (wheavy ? 25 : 75);
      for (int k = 0; k < 2; k++) begin
        wr_opcode[k] = 4'($urandom);
        wr_op_a[k] = 16'($urandom);
        wr_op_b[k] = 16'($urandom);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
